mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single unified instruction/data memory between the multicycle CPU core (port 0) and a program loader / DMA engine (port 1). It sits between the core's memory-select path and the memory model. It serialises one transaction at a time through a req/done handshake on each side. Round-robin grant guarantees that neither requester starves.

---
 rtl/mem_arb_pkg.sv | 35 +++
 rtl/rr_pick2.sv | 35 +++
 rtl/mem_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//
// Shared definitions for the unified-memory port arbiter.
//   - arb_state_t            : FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   - PORT_CPU / PORT_DMA    : bit index of each requester in grant/req vectors
//   - TIMEOUT_CYCLES_DEFAULT : default WAIT-state cycle limit
//   - timeoutCntWidth()      : width of the WAIT-state counter for a given limit
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    // The counter must be able to hold the limit itself and is never
    // narrower than 8 bits.
    function automatic int timeoutCntWidth(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        if (w < 8) begin
            w = 8;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
//
// Combinational two-way round-robin picker.
//   i_req   [1:0] : request vector, bit n = port n
//   i_last        : index of the port granted most recently
//   o_grant [1:0] : one-hot winner, 00 when nobody requests
// A lone requester always wins; on contention the port that was not
// granted last wins, so neither side can starve the other.
// ---------------------------------------------------------------------------
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        unique case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11: begin
                if (i_last == 1'(PORT_DMA)) begin
                    o_grant = 2'b01;
                end else begin
                    o_grant = 2'b10;
                end
            end
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single unified instruction/data memory between the CPU core
// (port 0) and the program loader / DMA engine (port 1). One transaction is
// in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN : request side of port N (N = 0 CPU, 1 DMA)
//   doneN                 : one-cycle completion pulse back to port N
//   rdata                 : read data, valid while any doneN is high
//   err                   : timeout flag, valid with doneN
//   mem_req               : one-cycle transaction strobe to memory
//   mem_we/addr/wdata     : latched transaction fields to memory
//   mem_rdata, mem_done   : memory response
//   busy                  : high whenever the FSM is not in IDLE
//   grant                 : one-hot owner of the current transaction
//
// Build option: define MEM_ARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYCLES cycles; a timed-out transaction completes with err=1 and
// rdata=0. Without it WAIT waits forever and err is tied low.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic          busy,
    output logic [1:0]    grant
);

    arb_state_t    r_state;
    arb_state_t    w_nextState;

    logic [1:0]    w_req;
    logic [1:0]    w_pick;
    logic          w_timeout;

    logic          r_lastGrant;
    logic [1:0]    r_grant;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;

    assign w_req = {req1, req0};

    rr_pick2 u_pick (
        .i_req   (w_req),
        .i_last  (r_lastGrant),
        .o_grant (w_pick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and state-decoded outputs. A timeout only matters when
    // mem_done is absent, so a simultaneous mem_done still completes normally.
    always_comb begin
        w_nextState = r_state;
        mem_req     = 1'b0;
        busy        = 1'b1;
        done0       = 1'b0;
        done1       = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (|w_req) begin
                    w_nextState = ISSUE;
                end
            end
            ISSUE: begin
                mem_req     = 1'b1;
                w_nextState = WAIT;
            end
            WAIT: begin
                if (mem_done || w_timeout) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                done0       = r_grant[PORT_CPU];
                done1       = r_grant[PORT_DMA];
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Transaction registers: the winner's fields are captured on the edge
    // leaving IDLE so later changes on the request side have no effect, and
    // the grant is released on the edge leaving RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lastGrant <= 1'(PORT_DMA);
            r_grant     <= 2'b00;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_grant     <= w_pick;
                        r_lastGrant <= w_pick[PORT_DMA];
                        if (w_pick[PORT_DMA]) begin
                            r_we    <= we1;
                            r_addr  <= addr1;
                            r_wdata <= wdata1;
                        end else begin
                            r_we    <= we0;
                            r_addr  <= addr0;
                            r_wdata <= wdata0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_done) begin
                        r_rdata <= mem_rdata;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                    end
                end
                RESP: begin
                    r_grant <= 2'b00;
                end
                default: begin
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = timeoutCntWidth(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_waitCnt;
    logic             r_err;

    assign w_timeout = (r_state == WAIT) && (r_waitCnt == CNT_W'(TIMEOUT_CYCLES));

    // The counter reads 0 on the first WAIT cycle and k on the (k+1)th, so
    // the FSM leaves WAIT once TIMEOUT_CYCLES full cycles have passed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_waitCnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == WAIT) begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end else begin
                r_waitCnt <= '0;
            end
            if (r_state == WAIT) begin
                if (mem_done) begin
                    r_err <= 1'b0;
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end else if (r_state == IDLE) begin
                r_err <= 1'b0;
            end
        end
    end

    assign err = r_err && (r_state == RESP);
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A table of single transactions is
// replayed cycle by cycle, followed by hand-written sequences for stray
// mem_done, reset during WAIT, sustained contention and (when
// MEM_ARB_TIMEOUT_EN is defined) the WAIT timeout with TIMEOUT_CYCLES=4.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        done0, done1, err, mem_req, mem_we, busy;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_done;
    logic [1:0]  grant;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        req0;
        logic        req1;
        logic        we0;
        logic        we1;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] wdata0;
        logic [31:0] wdata1;
        int          waitCycles;
        logic [31:0] memRdata;
        logic [1:0]  expGrant;
        logic [31:0] expAddr;
        logic        expWe;
        logic [31:0] expWdata;
        logic        checkRdata;
    } vec_t;

    vec_t vecs[7];

    mem_port_arbiter #(
        .AW             (32),
        .DW             (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .done0     (done0),
        .done1     (done1),
        .rdata     (rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .busy      (busy),
        .grant     (grant)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge, where outputs are settled
    // and new inputs are set up for the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison with failure reporting.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every output of the arbiter must be zero (reset state).
    task automatic checkAllZero(input string tag);
        checkOutput({tag, "/done0"},     64'(done0),     64'h0);
        checkOutput({tag, "/done1"},     64'(done1),     64'h0);
        checkOutput({tag, "/rdata"},     64'(rdata),     64'h0);
        checkOutput({tag, "/err"},       64'(err),       64'h0);
        checkOutput({tag, "/mem_req"},   64'(mem_req),   64'h0);
        checkOutput({tag, "/mem_we"},    64'(mem_we),    64'h0);
        checkOutput({tag, "/mem_addr"},  64'(mem_addr),  64'h0);
        checkOutput({tag, "/mem_wdata"}, 64'(mem_wdata), 64'h0);
        checkOutput({tag, "/busy"},      64'(busy),      64'h0);
        checkOutput({tag, "/grant"},     64'(grant),     64'h0);
    endtask

    // Run one complete transaction from an idle arbiter, checking each cycle.
    // Request-side inputs are scrambled after the grant to show they are
    // latched; memory answers after waitCycles idle WAIT cycles.
    task automatic applyStimulus(input vec_t v, input string tag);
        req0   = v.req0;   req1   = v.req1;
        we0    = v.we0;    we1    = v.we1;
        addr0  = v.addr0;  addr1  = v.addr1;
        wdata0 = v.wdata0; wdata1 = v.wdata1;
        checkOutput({tag, "/idle_busy"}, 64'(busy), 64'h0);
        tick();
        checkOutput({tag, "/issue_memreq"}, 64'(mem_req),   64'h1);
        checkOutput({tag, "/issue_grant"},  64'(grant),     64'(v.expGrant));
        checkOutput({tag, "/issue_busy"},   64'(busy),      64'h1);
        checkOutput({tag, "/issue_addr"},   64'(mem_addr),  64'(v.expAddr));
        checkOutput({tag, "/issue_we"},     64'(mem_we),    64'(v.expWe));
        checkOutput({tag, "/issue_wdata"},  64'(mem_wdata), 64'(v.expWdata));
        req0   = 1'b0;         req1   = 1'b0;
        we0    = ~v.we0;       we1    = ~v.we1;
        addr0  = 32'h99;       addr1  = 32'h99;
        wdata0 = 32'hFFFF_FFFF; wdata1 = 32'hFFFF_FFFF;
        tick();
        for (int i = 0; i < v.waitCycles; i++) begin
            checkOutput({tag, "/wait_memreq"}, 64'(mem_req),        64'h0);
            checkOutput({tag, "/wait_done"},   64'({done1, done0}), 64'h0);
            tick();
        end
        checkOutput({tag, "/wait_addr"},  64'(mem_addr),  64'(v.expAddr));
        checkOutput({tag, "/wait_we"},    64'(mem_we),    64'(v.expWe));
        checkOutput({tag, "/wait_wdata"}, 64'(mem_wdata), 64'(v.expWdata));
        mem_done  = 1'b1;
        mem_rdata = v.memRdata;
        tick();
        mem_done  = 1'b0;
        mem_rdata = 32'h0BAD_0BAD;
        checkOutput({tag, "/resp_done"},  64'({done1, done0}), 64'(v.expGrant));
        checkOutput({tag, "/resp_grant"}, 64'(grant),          64'(v.expGrant));
        checkOutput({tag, "/resp_err"},   64'(err),            64'h0);
        if (v.checkRdata) begin
            checkOutput({tag, "/resp_rdata"}, 64'(rdata), 64'(v.memRdata));
        end
        tick();
        checkOutput({tag, "/post_busy"},  64'(busy),           64'h0);
        checkOutput({tag, "/post_grant"}, 64'(grant),          64'h0);
        checkOutput({tag, "/post_done"},  64'({done1, done0}), 64'h0);
        if (v.checkRdata) begin
            checkOutput({tag, "/post_rdata_held"}, 64'(rdata), 64'(v.memRdata));
        end
    endtask

    initial begin
        logic [1:0]  contGrant[3];
        logic [31:0] contAddr[3];

        // req0 req1 we0 we1 addr0 addr1 wdata0 wdata1 wait memRdata grant addr we wdata chkRd
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0,
                    1, 32'hDEAD_BEEF, 2'b01, 32'h10, 1'b0, 32'h0, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h20, 32'h0, 32'h55,
                    2, 32'h7777_7777, 2'b10, 32'h20, 1'b1, 32'h55, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h44, 32'h0, 32'h0,
                    0, 32'h1234_5678, 2'b10, 32'h44, 1'b0, 32'h0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hABC, 32'h0, 32'hCAFE_F00D, 32'h0,
                    3, 32'h0, 2'b01, 32'hABC, 1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0,
                    0, 32'hA5A5_A5A5, 2'b01, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1};
        // Contested: port 0 won last, so port 1 wins, then port 0.
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 32'h0, 32'h0,
                    1, 32'h0BAD_F00D, 2'b10, 32'h200, 1'b0, 32'h0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h400, 32'h77, 32'h88,
                    0, 32'h0, 2'b01, 32'h300, 1'b1, 32'h77, 1'b0};

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_rdata = '0; mem_done = 1'b0;
        tick();
        tick();
        checkAllZero("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Stray mem_done in an empty IDLE.
        mem_done = 1'b1;
        tick();
        checkOutput("spur_idle_busy", 64'(busy),           64'h0);
        checkOutput("spur_idle_done", 64'({done1, done0}), 64'h0);
        // mem_done high while a request is accepted and through ISSUE.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h80;
        mem_rdata = 32'h1111_1111;
        tick();
        checkOutput("spur_issue_memreq", 64'(mem_req), 64'h1);
        checkOutput("spur_issue_grant",  64'(grant),   64'h1);
        req0 = 1'b0;
        tick();
        mem_done = 1'b0;
        checkOutput("spur_wait_done", 64'({done1, done0}), 64'h0);
        checkOutput("spur_wait_busy", 64'(busy),           64'h1);
        tick();
        checkOutput("spur_wait2_done", 64'({done1, done0}), 64'h0);
        mem_done = 1'b1;
        mem_rdata = 32'h2222_2222;
        tick();
        mem_done = 1'b0;
        checkOutput("spur_resp_done",  64'({done1, done0}), 64'h1);
        checkOutput("spur_resp_rdata", 64'(rdata),          64'h2222_2222);
        tick();

        // Reset during WAIT of a port 1 write: everything clears, no done.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h1234; wdata1 = 32'hA5A5;
        tick();
        req1 = 1'b0;
        tick();
        checkOutput("rst_wait_busy", 64'(busy), 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkAllZero("rst_mid");
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        checkOutput("rst_post_done", 64'({done1, done0}), 64'h0);
        checkOutput("rst_post_busy", 64'(busy),           64'h0);
        tick();
        checkOutput("rst_post2_done", 64'({done1, done0}), 64'h0);

        // Sustained contention right after reset: port 0, port 1, port 0,
        // one transaction every 4 cycles with zero memory wait.
        contGrant[0] = 2'b01; contGrant[1] = 2'b10; contGrant[2] = 2'b01;
        contAddr[0]  = 32'h1000; contAddr[1] = 32'h2000; contAddr[2] = 32'h1000;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h1000; addr1 = 32'h2000;
        for (int t = 0; t < 3; t++) begin
            tick();
            checkOutput($sformatf("cont%0d_grant", t),  64'(grant),    64'(contGrant[t]));
            checkOutput($sformatf("cont%0d_memreq", t), 64'(mem_req),  64'h1);
            checkOutput($sformatf("cont%0d_addr", t),   64'(mem_addr), 64'(contAddr[t]));
            tick();
            mem_done = 1'b1;
            mem_rdata = 32'hC0DE_0000 + 32'(t);
            tick();
            mem_done = 1'b0;
            checkOutput($sformatf("cont%0d_done", t),  64'({done1, done0}), 64'(contGrant[t]));
            checkOutput($sformatf("cont%0d_rdata", t), 64'(rdata),          64'(32'hC0DE_0000 + 32'(t)));
            tick();
            checkOutput($sformatf("cont%0d_idle", t), 64'(busy), 64'h0);
            if (t == 2) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        tick();
        checkOutput("cont_end_busy", 64'(busy), 64'h0);

`ifdef MEM_ARB_TIMEOUT_EN
        // No mem_done: done0 with err=1 and rdata=0 seven cycles after the request.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
        tick();
        req0 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            checkOutput($sformatf("tmo_cycle%0d_done", k), 64'({done1, done0}), 64'h0);
            tick();
        end
        checkOutput("tmo_done",  64'({done1, done0}), 64'h1);
        checkOutput("tmo_err",   64'(err),            64'h1);
        checkOutput("tmo_rdata", 64'(rdata),          64'h0);
        tick();
        checkOutput("tmo_post_busy", 64'(busy), 64'h0);
        checkOutput("tmo_post_err",  64'(err),  64'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
